mult_ctrl: RTL and testbench
============================

# mult_ctrl

Control unit for the 16×16 shift-and-add multiplier datapath. It sequences the accumulator/shift register's Load, Sh and Ad strobes from a Start request, uses the accumulator's LSB to decide add-versus-shift, counts shifts, and reports completion with a Done/Busy handshake. It sits directly upstream of the accumulator register and drives only its control inputs; the 17-bit adder and operand registers stay in the datapath.

## Interface
- WIDTH, 16: multiplier operand width; equals the number of shifts per multiply.
- CW, $clog2(WIDTH+1): shift counter width (5 for WIDTH=16).

- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; forces IDLE immediately.
- Start  input  1  multiply request, sampled in IDLE and DONE.
- M  input  1  accumulator bit 0 (current multiplier bit).
- Load  output  1  load accumulator from operands (one cycle per multiply).
- Sh  output  1  shift accumulator right by one.
- Ad  output  1  write adder result into accumulator upper half.
- Done  output  1  product valid in accumulator; held while in DONE.
- Busy  output  1  high in LOAD, SHIFT, TEST.
- Count  output  CW  shifts completed in the current multiply.

## Operation
- States: IDLE, LOAD, SHIFT, TEST, DONE. Registered state, 5-bit one-hot or binary (implementer's choice); outputs decoded combinationally from state and M.
- IDLE: all strobes 0. Start=1 → LOAD; Count cleared to 0.
- LOAD: Load=1. Accumulator captures operand and conditional first add (bit 0) at this edge. → SHIFT.
- SHIFT: Sh=1; Count increments at the edge. If Count==WIDTH-1 (last shift) → DONE, else → TEST.
- TEST: M sampled after the previous shift settled.
  - M=1: Ad=1, Sh=0, Count unchanged → SHIFT.
  - M=0: Sh=1, Count increments; same transition rule as SHIFT (last shift → DONE, else stay TEST).
- DONE: Done=1, Busy=0, Count holds WIDTH. Start=1 → LOAD (Count cleared, back-to-back multiply); Start=0 → stay DONE.
- Load, Sh, Ad mutually exclusive in every state; never two high in one cycle.
- Exactly WIDTH shifts per multiply; at most WIDTH-1 adds (bits 1..WIDTH-1).
- Start ignored in LOAD/SHIFT/TEST.

## Timing
- Reset: state IDLE, Count=0; Load=Sh=Ad=Done=Busy=0 immediately on Reset assertion, independent of Clk.
- Reset mid-multiply: abandons operation; strobes drop asynchronously; no Done. Accumulator contents undefined for the bench.
- Start sampled at edge N in IDLE → Load high cycle N+1.
- Cycles from first Load cycle to first Done cycle: 1 + WIDTH + k, k = number of 1s in multiplier bits [WIDTH-1:1]. WIDTH=16: minimum 17, maximum 32.
- Done rises the cycle after the last Sh cycle; product stable in accumulator from that cycle while Start=0.
- Count changes only on Sh cycles (and clear on LOAD entry).

## Configuration
- MULT_CTRL_ABORT_EN defined: adds input Abort (1 bit). Abort=1 at an edge in LOAD, SHIFT or TEST → IDLE next cycle, Count=0, no Done; Abort has priority over all transitions; ignored in IDLE and DONE.
- Undefined: no Abort port; multiply always runs to DONE unless Reset.

## Test plan
- Reset during idle and mid-SHIFT → all outputs 0 within the same cycle, state IDLE, Count=0.
- Controller + accumulator + adder, 0x0003×0x0005 → Done 18 cycles after first Load, product 0x0000000F, one Ad pulse, 16 Sh pulses.
- 0xFFFF×0xFFFF (multiplier 0xFFFF) → 32 cycles Load-to-Done, 15 Ad pulses, product 0xFFFE0001; no two strobes coincide.
- Multiplier 0x0000, multiplicand 0x1234 → 17 cycles, zero Ad pulses, product 0; Start pulsed mid-run has no effect.
- Start held high through DONE → Done high exactly one cycle, Load next cycle, second product (0x0002×0x0007=0x0000000E) correct.
- With MULT_CTRL_ABORT_EN: Abort at 5th Sh cycle → IDLE next cycle, Busy=0, Done never asserted, next Start runs a full correct multiply.

Source files
------------

// File: rtl/mult_ctrl_if.sv
// mult_ctrl_if: control handshake between the shift-and-add multiplier
// controller (slave) and the requester/accumulator side (master).
// The Abort signal exists only when MULT_CTRL_ABORT_EN is defined.
interface mult_ctrl_if #(
    parameter int CW = 5
);
    logic          Start;
    logic          M;
    logic          Load;
    logic          Sh;
    logic          Ad;
    logic          Done;
    logic          Busy;
    logic [CW-1:0] Count;
`ifdef MULT_CTRL_ABORT_EN
    logic          Abort;

    modport master (output Start, M, Abort, input Load, Sh, Ad, Done, Busy, Count);
    modport slave  (input Start, M, Abort, output Load, Sh, Ad, Done, Busy, Count);
`else
    modport master (output Start, M, input Load, Sh, Ad, Done, Busy, Count);
    modport slave  (input Start, M, output Load, Sh, Ad, Done, Busy, Count);
`endif
endinterface

// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencer for a WIDTH x WIDTH shift-and-add multiplier.
// Issues one Load, then WIDTH shifts interleaved with an add before each
// shift whose multiplier bit (seen on M) is 1. Outputs decode from state.
// Optional feature: define MULT_CTRL_ABORT_EN to add the Abort input, which
// returns a running multiply to IDLE without Done.
module mult_ctrl #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic           Clk,
    input  logic           Reset,
    mult_ctrl_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_TEST,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          load, sh, ad, done, busy;
    logic          last_shift;

    // The shift issued while Count is WIDTH-1 is the final one.
    assign last_shift = (count_q == CW'(WIDTH - 1));

    // State and shift counter registers; Reset forces IDLE asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values computed by the combinational block.
        if (Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, counter update and strobe decode from state and M.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned (which would infer a latch).
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        sh      = 1'b0;
        ad      = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                busy    = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sh      = 1'b1;
                busy    = 1'b1;
                count_d = count_q + CW'(1);
                state_d = last_shift ? S_DONE : S_TEST;
            end
            S_TEST: begin
                busy = 1'b1;
                if (bus.M) begin
                    // Add first, then the following SHIFT state shifts.
                    ad      = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    sh      = 1'b1;
                    count_d = count_q + CW'(1);
                    state_d = last_shift ? S_DONE : S_TEST;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (bus.Start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

`ifdef MULT_CTRL_ABORT_EN
        // Abort overrides every transition while a multiply is running.
        if (bus.Abort && busy) begin
            state_d = S_IDLE;
            count_d = '0;
        end
`endif
    end

    assign bus.Load  = load;
    assign bus.Sh    = sh;
    assign bus.Ad    = ad;
    assign bus.Done  = done;
    assign bus.Busy  = busy;
    assign bus.Count = count_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: drives mult_ctrl together with a behavioural accumulator and
// adder, and checks results against a reference model built from plain
// multiplication and bit counts of the operands.
module tb_mult_ctrl;

    localparam int WIDTH = 16;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk;
    logic rst;

    mult_ctrl_if #(.CW(CW)) bus ();

    mult_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Datapath environment: operand registers and 33-bit accumulator.
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [32:0] acc;
    logic        ld_s, sh_s, ad_s;

    assign bus.M = acc[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes are sampled mid-cycle so the accumulator acts on settled values.
    always @(negedge clk) begin
        ld_s <= bus.Load;
        sh_s <= bus.Sh;
        ad_s <= bus.Ad;
    end

    always @(posedge clk) begin
        if (ld_s)
            acc <= {1'b0, (mplier[0] ? mcand : 16'h0000), mplier};
        else if (ad_s)
            acc[32:16] <= {1'b0, acc[31:16]} + {1'b0, mcand};
        else if (sh_s)
            acc <= {1'b0, acc[32:1]};
    end

    // Launch one multiply from IDLE/DONE (caller sits at a negedge) and
    // compare its timing, strobe counts and product against the model.
    task automatic run_multiply(input string tag, input logic [15:0] a, input logic [15:0] b,
                                input bit hold_start, input int pulse_at);
        int          cyc, ads, shs, lds, k, exp_cyc;
        bit          overlap, busy_drop, count_bad, done_seen;
        logic [31:0] exp_p;
        k       = $countones(b[15:1]);
        exp_cyc = 1 + WIDTH + k;
        exp_p   = 32'(a) * 32'(b);

        mcand     = a;
        mplier    = b;
        bus.Start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.Load, bus.Busy, bus.Done, bus.Count} !== {3'b110, 5'd0}) begin
            n_fail++;
            $display("FAIL %s load_cycle: Load/Busy/Done=%b Count=%0d, expected 110 Count=0",
                     tag, {bus.Load, bus.Busy, bus.Done}, bus.Count);
        end
        if (!hold_start) bus.Start = 1'b0;

        cyc = 0; ads = 0; shs = 0; lds = 0;
        overlap = 0; busy_drop = 0; count_bad = 0; done_seen = 0;
        if (bus.Sh) shs++;
        for (int i = 0; i < 64 && !done_seen; i++) begin
            @(negedge clk);
            cyc++;
            if (pulse_at > 0) begin
                if (cyc == pulse_at) bus.Start = 1'b1;
                else if (cyc == pulse_at + 1) bus.Start = 1'b0;
            end
            if (bus.Done) done_seen = 1;
            else if (!bus.Busy) busy_drop = 1;
            if (int'(bus.Count) != shs) count_bad = 1;
            if (int'(bus.Load) + int'(bus.Sh) + int'(bus.Ad) > 1) overlap = 1;
            if (bus.Load) lds++;
            if (bus.Sh) shs++;
            if (bus.Ad) ads++;
        end

        n_checks++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL %s done_timeout: no Done within 64 cycles, required by cycle %0d", tag, exp_cyc);
        end
        n_checks++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s latency: Load-to-Done %0d cycles, expected %0d", tag, cyc, exp_cyc);
        end
        n_checks++;
        if (ads != k || shs != WIDTH || lds != 0) begin
            n_fail++;
            $display("FAIL %s pulses: Ad=%0d Sh=%0d extraLoad=%0d, expected Ad=%0d Sh=%0d extraLoad=0",
                     tag, ads, shs, lds, k, WIDTH);
        end
        n_checks++;
        if (overlap || busy_drop || count_bad) begin
            n_fail++;
            $display("FAIL %s run_flags: overlap=%0d busy_drop=%0d count_bad=%0d, expected all 0",
                     tag, overlap, busy_drop, count_bad);
        end
        n_checks++;
        if (acc[31:0] !== exp_p) begin
            n_fail++;
            $display("FAIL %s product: %h x %h gave %h, expected %h", tag, a, b, acc[31:0], exp_p);
        end
        n_checks++;
        if ({bus.Busy, bus.Count} !== {1'b0, 5'(WIDTH)}) begin
            n_fail++;
            $display("FAIL %s done_state: Busy=%b Count=%0d, expected Busy=0 Count=%0d",
                     tag, bus.Busy, bus.Count, WIDTH);
        end
    endtask

    task automatic test_reset();
        bit saw_shift;
        // Reset while idle.
        rst = 1'b1;
        bus.Start = 1'b0;
        #1;
        n_checks++;
        if ({bus.Load, bus.Sh, bus.Ad, bus.Done, bus.Busy, bus.Count} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs=%b Count=%0d, expected all 0",
                     {bus.Load, bus.Sh, bus.Ad, bus.Done, bus.Busy}, bus.Count);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.Busy, bus.Done, bus.Load} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: Busy/Done/Load=%b, expected 000", {bus.Busy, bus.Done, bus.Load});
        end

        // Reset in the middle of a multiply, between clock edges.
        mcand = 16'h00FF; mplier = 16'h0FF0; bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        saw_shift = 0;
        for (int i = 0; i < 40 && !saw_shift; i++) begin
            @(negedge clk);
            if (bus.Sh && bus.Count >= 5'd3) saw_shift = 1;
        end
        n_checks++;
        if (!saw_shift) begin
            n_fail++;
            $display("FAIL reset_mid_setup: shift with Count>=3 not seen in 40 cycles");
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.Load, bus.Sh, bus.Ad, bus.Done, bus.Busy, bus.Count} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: outputs=%b Count=%0d, expected all 0 before next edge",
                     {bus.Load, bus.Sh, bus.Ad, bus.Done, bus.Busy}, bus.Count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.Done, bus.Busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_no_done: Done/Busy=%b, expected 00", {bus.Done, bus.Busy});
            end
        end
    endtask

    task automatic test_small();
        run_multiply("small_3x5", 16'h0003, 16'h0005, 1'b0, 0);
    endtask

    task automatic test_max();
        run_multiply("max_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 0);
    endtask

    task automatic test_zero_mid_start();
        @(negedge clk);
        run_multiply("zero_mplier", 16'h1234, 16'h0000, 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
        run_multiply("b2b_first", a, b, 1'b1, 0);
        run_multiply("b2b_second", 16'h0002, 16'h0007, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int t = 0; t < 16; t++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            if (t == 0) b = 16'h0001;
            if (t == 1) b = 16'h8000;
            @(negedge clk);
            run_multiply("random", a, b, 1'b0, 0);
        end
    endtask

`ifdef MULT_CTRL_ABORT_EN
    task automatic test_abort();
        int shs;
        bit hit, done_seen;
        mcand = 16'hABCD; mplier = 16'h5A5A; bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        shs = 0; hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.Sh) shs++;
            if (shs == 5) hit = 1;
        end
        bus.Abort = 1'b1;
        @(negedge clk);
        bus.Abort = 1'b0;
        n_checks++;
        if (!hit || {bus.Load, bus.Sh, bus.Ad, bus.Done, bus.Busy, bus.Count} !== 10'd0) begin
            n_fail++;
            $display("FAIL abort_idle: hit=%0d outputs=%b Count=%0d, expected idle with Count=0",
                     hit, {bus.Load, bus.Sh, bus.Ad, bus.Done, bus.Busy}, bus.Count);
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) done_seen = 1;
        end
        n_checks++;
        if (done_seen) begin
            n_fail++;
            $display("FAIL abort_no_done: Done or Busy seen after abort, expected neither");
        end
        run_multiply("after_abort", 16'h1357, 16'h2468, 1'b0, 0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        acc       = '0;
        mcand     = '0;
        mplier    = '0;
        bus.Start = 1'b0;
`ifdef MULT_CTRL_ABORT_EN
        bus.Abort = 1'b0;
`endif
        test_reset();
        test_small();
        test_max();
        test_zero_mid_start();
        test_back_to_back();
        test_random();
`ifdef MULT_CTRL_ABORT_EN
        @(negedge clk);
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
